// File: rtl/bus_arbiter_mux.sv
// Registered bus arbiter/mux: round-robin, or lowest-index-first when BUS_ARB_FIXED_PRIORITY_EN is defined.
// Latency 1 cycle; no backpressure: one grant per cycle, losing requesters retry later.
module bus_arbiter_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 24,
  localparam int SEL_W  = $clog2(NUM_SRC)
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NUM_SRC-1:0]       Bus_enable,
  input  logic [NUM_SRC*WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0]         busMuxOut,
  output logic [NUM_SRC-1:0]       bus_grant,
  output logic [SEL_W-1:0]         grant_sel,
  output logic                     bus_valid,
  output logic                     bus_conflict,
  output logic [7:0]               conflict_count
);

  logic [WIDTH-1:0]   r_bus;
  logic [NUM_SRC-1:0] r_grant;
  logic [SEL_W-1:0]   r_sel;
  logic               r_valid;
  logic               r_conflict;
  logic [7:0]         r_count;

  logic               w_any;
  logic               w_conflict;
  logic [SEL_W-1:0]   w_win;
  logic [WIDTH-1:0]   w_win_dat;

  assign w_any      = |Bus_enable;
  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_conflict = |(Bus_enable & (Bus_enable - NUM_SRC'(1)));

`ifdef BUS_ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (Bus_enable[i]) w_win = SEL_W'(i);
    end
  end
`else
  logic [SEL_W-1:0] r_rr_ptr;
  logic             w_found;
  int               w_idx;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
      if (!w_found && Bus_enable[w_idx]) begin
        w_found = 1'b1;
        w_win   = SEL_W'(w_idx);
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= (w_win == SEL_W'(NUM_SRC - 1)) ? '0 : w_win + SEL_W'(1);
    end
  end
`endif

  assign w_win_dat = bus_in[int'(w_win)*WIDTH +: WIDTH];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_bus      <= '0;
      r_grant    <= '0;
      r_sel      <= '0;
      r_valid    <= 1'b0;
      r_conflict <= 1'b0;
      r_count    <= '0;
    end else begin
      r_valid    <= w_any;
      r_conflict <= w_conflict;
      if (w_any) begin
        r_bus   <= w_win_dat;
        r_grant <= NUM_SRC'(1) << w_win;
        r_sel   <= w_win;
      end else begin
        r_grant <= '0;
      end
      if (w_conflict && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
    end
  end

  assign busMuxOut      = r_bus;
  assign bus_grant      = r_grant;
  assign grant_sel      = r_sel;
  assign bus_valid      = r_valid;
  assign bus_conflict   = r_conflict;
  assign conflict_count = r_count;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: directed test-plan steps plus random traffic against a reference model.
module tb_bus_arbiter_mux;
  localparam int W  = 32;
  localparam int NS = 24;
  localparam int SW = $clog2(NS);

  logic              clock = 1'b0;
  logic              clear = 1'b0;
  logic [NS-1:0]     Bus_enable = '0;
  logic [NS*W-1:0]   bus_in = '0;
  logic [W-1:0]      busMuxOut;
  logic [NS-1:0]     bus_grant;
  logic [SW-1:0]     grant_sel;
  logic              bus_valid;
  logic              bus_conflict;
  logic [7:0]        conflict_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] lane_dat [NS];

  // Reference model state
  logic [W-1:0]  m_bus;
  logic [NS-1:0] m_grant;
  int            m_sel;
  logic          m_valid;
  logic          m_conf;
  int            m_cnt;
  int            m_ptr;

  bus_arbiter_mux #(.WIDTH(W), .NUM_SRC(NS)) dut (
    .clock(clock), .clear(clear), .Bus_enable(Bus_enable), .bus_in(bus_in),
    .busMuxOut(busMuxOut), .bus_grant(bus_grant), .grant_sel(grant_sel),
    .bus_valid(bus_valid), .bus_conflict(bus_conflict), .conflict_count(conflict_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner = requester nearest at/after the pointer going upward with wrap (or lowest index).
  function automatic int pick(input logic [NS-1:0] en);
    int best = -1;
    int bestd = NS;
    for (int i = 0; i < NS; i++) begin
      if (en[i]) begin
        int d;
`ifdef BUS_ARB_FIXED_PRIORITY_EN
        d = i;
`else
        d = (i - m_ptr + NS) % NS;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_bus = '0; m_grant = '0; m_sel = 0; m_valid = 0; m_conf = 0; m_cnt = 0; m_ptr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bus"},   busMuxOut,      m_bus);
    chk({tag, ".grant"}, bus_grant,      m_grant);
    chk({tag, ".sel"},   grant_sel,      m_sel);
    chk({tag, ".valid"}, bus_valid,      m_valid);
    chk({tag, ".conf"},  bus_conflict,   m_conf);
    chk({tag, ".cnt"},   conflict_count, m_cnt);
  endtask

  // Called just after a rising edge: drive, let the next edge sample, update model, check.
  task automatic step(input logic [NS-1:0] en, input string tag);
    Bus_enable = en;
    for (int i = 0; i < NS; i++) bus_in[i*W +: W] = en[i] ? lane_dat[i] : {W{1'bx}};
    @(posedge clock);
    if (en != '0) begin
      int w = pick(en);
      m_bus   = lane_dat[w];
      m_grant = NS'(1) << w;
      m_sel   = w;
      m_valid = 1'b1;
      m_ptr   = (w + 1) % NS;
    end else begin
      m_valid = 1'b0;
      m_grant = '0;
    end
    m_conf = ($countones(en) > 1);
    if (m_conf && m_cnt < 255) m_cnt++;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    clear = 1'b0;
    Bus_enable = '0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NS; i++) lane_dat[i] = $urandom;
    #3;
    check_all("reset");
    do_reset();
    check_all("reset_rel");

    // Single request
    lane_dat[3] = 32'hDEADBEEF;
    step(24'h000008, "single");
    chk("single.bus_lit", busMuxOut, 32'hDEADBEEF);
    chk("single.sel_lit", grant_sel, 3);
    chk("single.grant_lit", bus_grant, 24'h000008);

    // Idle hold
    for (int i = 0; i < 3; i++) begin
      step('0, "idle");
      chk("idle.bus_lit", busMuxOut, 32'hDEADBEEF);
    end

    // Rotation with wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lane_dat[0] = $urandom; lane_dat[23] = $urandom;
      step(24'h800001, "rot");
`ifdef BUS_ARB_FIXED_PRIORITY_EN
      chk("rot.sel_lit", grant_sel, 0);
`else
      chk("rot.sel_lit", grant_sel, (i % 2 == 0) ? 0 : 23);
`endif
      chk("rot.conf_lit", bus_conflict, 1);
    end
    chk("rot.cnt_lit", conflict_count, 4);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      lane_dat[7] = $urandom; lane_dat[12] = $urandom;
      step(24'h001080, "sat");
    end
    chk("sat.cnt_lit", conflict_count, 255);
    step(24'h000080, "sat_single");
    chk("sat.conf_clr", bus_conflict, 0);

    // Async reset mid-burst
    do_reset();
    for (int i = 0; i < 5; i++) begin
      lane_dat[9] = $urandom; lane_dat[4] = $urandom;
      step(24'h000210, "burst");
    end
    #3;
    clear = 1'b0;
    Bus_enable = '0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    step('0, "post_rel");
    lane_dat[2] = $urandom; lane_dat[5] = $urandom;
    step(24'h000024, "post_rel_req");
    chk("post_rel.sel_lit", grant_sel, 2);

    // Priority pattern from reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(24'h000024, "prio");
`ifdef BUS_ARB_FIXED_PRIORITY_EN
      chk("prio.sel_lit", grant_sel, 2);
`endif
    end

    // Random traffic, sparse and dense request patterns
    for (int i = 0; i < 400; i++) begin
      logic [NS-1:0] en;
      for (int j = 0; j < NS; j++) lane_dat[j] = $urandom;
      case ($urandom_range(0, 3))
        0: en = '0;
        1: en = NS'(1) << $urandom_range(0, NS - 1);
        2: en = NS'($urandom & $urandom & $urandom);
        default: en = NS'($urandom);
      endcase
      step(en, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
